// File: rtl/mem_load_store_master.sv
// Load/store initiator for the on-chip memory interface. It takes one byte-addressed request
// at a time, steers store data onto byte lanes, extends load data, and aborts when no ack arrives.
module mem_load_store_master #(
    parameter int XLEN           = 32,
    parameter int MEM_ADDR_BITS  = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                     clk,
    input  logic                     sync_reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_is_store,
    input  logic [2:0]               req_width,
    input  logic [31:0]              req_addr,
    input  logic [XLEN-1:0]          req_wdata,
    output logic [MEM_ADDR_BITS-1:0] mem_addr,
    output logic                     mem_read_en,
    output logic [XLEN/8-1:0]        mem_write_en,
    output logic [XLEN-1:0]          mem_write_data,
    input  logic [XLEN-1:0]          mem_read_data,
    input  logic                     mem_read_ack,
    input  logic                     mem_write_ack,
    output logic                     rsp_valid,
    output logic [XLEN-1:0]          rsp_rdata,
    output logic                     rsp_misaligned,
    output logic                     rsp_timeout
);
    localparam int LANES = XLEN / 8;

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ACTIVE, RESP} state_t;

    state_t                   state_r, state_s;
    logic [2:0]               width_r, width_s;
    logic [1:0]               lo_r, lo_s;
    logic [7:0]               cnt_r, cnt_s;
    logic                     ready_s, read_en_s, rsp_valid_s, mis_s, to_s;
    logic [MEM_ADDR_BITS-1:0] addr_s;
    logic [LANES-1:0]         write_en_s;
    logic [XLEN-1:0]          wdata_s, rdata_s;
    logic                     unused_s;

    assign unused_s = ^req_addr[31:MEM_ADDR_BITS+2];

    function automatic logic is_illegal(input logic is_store, input logic [2:0] width,
                                        input logic [1:0] lo);
        logic bad;
        case (width)
            3'b000:  bad = 1'b0;
            3'b001:  bad = lo[0];
            3'b010:  bad = (lo != 2'b00);
            3'b100:  bad = is_store;
            3'b101:  bad = is_store | lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [LANES-1:0] lane_enables(input logic [2:0] width,
                                                      input logic [1:0] lo);
        logic [LANES-1:0] one;
        logic [LANES-1:0] two;
        logic [LANES-1:0] en;
        one = {{(LANES-1){1'b0}}, 1'b1};
        two = {{(LANES-2){1'b0}}, 2'b11};
        case (width[1:0])
            2'b00:   en = one << lo;
            2'b01:   en = two << {lo[1], 1'b0};
            2'b10:   en = {LANES{1'b1}};
            default: en = {LANES{1'b0}};
        endcase
        return en;
    endfunction

    function automatic logic [XLEN-1:0] steer_data(input logic [2:0] width,
                                                   input logic [XLEN-1:0] wdata);
        logic [XLEN-1:0] d;
        case (width[1:0])
            2'b00:   d = {LANES{wdata[7:0]}};
            2'b01:   d = {(LANES/2){wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    // Lane shift uses the full low address; halfwords are already known to be aligned.
    function automatic logic [XLEN-1:0] extract(input logic [2:0] width, input logic [1:0] lo,
                                                input logic [XLEN-1:0] rd);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] v;
        sh = rd >> {lo, 3'b000};
        case (width)
            3'b000:  v = {{(XLEN-8){sh[7]}}, sh[7:0]};
            3'b100:  v = {{(XLEN-8){1'b0}}, sh[7:0]};
            3'b001:  v = {{(XLEN-16){sh[15]}}, sh[15:0]};
            3'b101:  v = {{(XLEN-16){1'b0}}, sh[15:0]};
            3'b010:  v = rd;
            default: v = {XLEN{1'b0}};
        endcase
        return v;
    endfunction

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_s     = state_r;
        width_s     = width_r;
        lo_s        = lo_r;
        cnt_s       = cnt_r;
        addr_s      = mem_addr;
        read_en_s   = 1'b0;
        write_en_s  = mem_write_en;
        wdata_s     = mem_write_data;
        rsp_valid_s = 1'b0;
        rdata_s     = {XLEN{1'b0}};
        mis_s       = 1'b0;
        to_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    width_s = req_width;
                    lo_s    = req_addr[1:0];
                    if (is_illegal(req_is_store, req_width, req_addr[1:0])) begin
                        state_s     = RESP;
                        rsp_valid_s = 1'b1;
                        mis_s       = 1'b1;
                    end else if (req_is_store) begin
                        state_s    = WR_ACTIVE;
                        addr_s     = req_addr[MEM_ADDR_BITS+1:2];
                        write_en_s = lane_enables(req_width, req_addr[1:0]);
                        wdata_s    = steer_data(req_width, req_wdata);
                        cnt_s      = 8'd0;
                    end else begin
                        state_s   = RD_ISSUE;
                        addr_s    = req_addr[MEM_ADDR_BITS+1:2];
                        read_en_s = 1'b1;
                        cnt_s     = 8'd0;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD_ISSUE: begin
                state_s = RD_WAIT;
                cnt_s   = cnt_r + 8'd1;
            end
            RD_WAIT: begin
                if (mem_read_ack) begin
                    state_s     = RESP;
                    rsp_valid_s = 1'b1;
                    rdata_s     = extract(width_r, lo_r, mem_read_data);
                end else if (cnt_r == 8'(TIMEOUT_CYCLES)) begin
                    state_s     = RESP;
                    rsp_valid_s = 1'b1;
                    to_s        = 1'b1;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            WR_ACTIVE: begin
                if (mem_write_ack) begin
                    state_s     = RESP;
                    rsp_valid_s = 1'b1;
                    write_en_s  = {LANES{1'b0}};
                end else if (cnt_r == 8'(TIMEOUT_CYCLES)) begin
                    state_s     = RESP;
                    rsp_valid_s = 1'b1;
                    to_s        = 1'b1;
                    write_en_s  = {LANES{1'b0}};
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s    = IDLE;
                write_en_s = {LANES{1'b0}};
            end
        endcase
        ready_s = (state_s == IDLE);
    end

    // State, request context and registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_r        <= IDLE;
            width_r        <= 3'b000;
            lo_r           <= 2'b00;
            cnt_r          <= 8'd0;
            req_ready      <= 1'b1;
            mem_addr       <= {MEM_ADDR_BITS{1'b0}};
            mem_read_en    <= 1'b0;
            mem_write_en   <= {LANES{1'b0}};
            mem_write_data <= {XLEN{1'b0}};
            rsp_valid      <= 1'b0;
            rsp_rdata      <= {XLEN{1'b0}};
            rsp_misaligned <= 1'b0;
            rsp_timeout    <= 1'b0;
        end else begin
            state_r        <= state_s;
            width_r        <= width_s;
            lo_r           <= lo_s;
            cnt_r          <= cnt_s;
            req_ready      <= ready_s;
            mem_addr       <= addr_s;
            mem_read_en    <= read_en_s;
            mem_write_en   <= write_en_s;
            mem_write_data <= wdata_s;
            rsp_valid      <= rsp_valid_s;
            rsp_rdata      <= rdata_s;
            rsp_misaligned <= mis_s;
            rsp_timeout    <= to_s;
        end
    end
endmodule

// File: tb/tb_mem_load_store_master.sv
// Directed bench for mem_load_store_master: a transaction-level model predicts strobes and
// responses per cycle, and a single compare process checks the DUT on every falling edge.
module tb_mem_load_store_master;
    localparam int T = 15;

    logic        clk, sync_reset, req_valid, req_ready, req_is_store;
    logic [2:0]  req_width;
    logic [31:0] req_addr, req_wdata;
    logic [15:0] mem_addr;
    logic        mem_read_en;
    logic [3:0]  mem_write_en;
    logic [31:0] mem_write_data, mem_read_data;
    logic        mem_read_ack, mem_write_ack;
    logic        rsp_valid, rsp_misaligned, rsp_timeout;
    logic [31:0] rsp_rdata;

    int total = 0, bad = 0, cyc = 0, acc = 0;
    logic checking = 1'b0, wr_ack_on = 1'b1;
    int rd_lat = -1;
    logic [31:0] rd_word = 32'h0;
    int exp_rsp = -1, exp_rd = -1, exp_wr_from = -1, exp_wr_to = -2, busy_from = -1, busy_to = -2;
    logic [31:0] exp_rdata = 32'h0, exp_wdata = 32'h0;
    logic [3:0]  exp_wen = 4'h0;
    logic [15:0] exp_waddr = 16'h0;
    logic        exp_mis = 1'b0, exp_to = 1'b0;
    logic [31:0] got_rdata = 32'h0;
    logic        got_mis = 1'b0, got_to = 1'b0;
    int          got_cyc = 0;

    mem_load_store_master #(.XLEN(32), .MEM_ADDR_BITS(16), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .sync_reset(sync_reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_width(req_width), .req_addr(req_addr),
        .req_wdata(req_wdata), .mem_addr(mem_addr), .mem_read_en(mem_read_en),
        .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_read_ack(mem_read_ack),
        .mem_write_ack(mem_write_ack), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_misaligned(rsp_misaligned), .rsp_timeout(rsp_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_write_ack = wr_ack_on & (|mem_write_en);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int access_size(input logic [2:0] w);
        case (w)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic model_illegal(input logic st, input logic [2:0] w, input logic [31:0] a);
        int size = access_size(w);
        if (size == 0) return 1'b1;
        if (st && w[2]) return 1'b1;
        return (a % size) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] w, input logic [31:0] a,
                                               input logic [31:0] word);
        logic [31:0] v;
        int off = int'(a % 4);
        case (w)
            3'b000, 3'b100: begin
                v = (word >> (8 * off)) & 32'h0000_00FF;
                if (w == 3'b000 && v >= 32'd128) v = v | 32'hFFFF_FF00;
            end
            3'b001, 3'b101: begin
                v = (word >> (8 * off)) & 32'h0000_FFFF;
                if (w == 3'b001 && v >= 32'd32768) v = v | 32'hFFFF_0000;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    // Predict the whole transaction, then present it to the DUT for one accepting edge.
    task automatic issue(input logic st, input logic [2:0] w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] word, input int lat);
        int A = cyc + 1;
        int k;
        acc = A;
        rd_word = word;
        rd_lat = lat;
        busy_from = A;
        exp_mis = 1'b0;
        exp_to = 1'b0;
        exp_rdata = 32'h0;
        exp_waddr = a[17:2];
        if (model_illegal(st, w, a)) begin
            exp_mis = 1'b1;
            exp_rsp = A;
        end else if (st) begin
            exp_wr_from = A;
            exp_wen = 4'(((1 << access_size(w)) - 1) << (a % 4));
            exp_wdata = (w == 3'b000) ? wd[7:0] * 32'h0101_0101 :
                        (w == 3'b001) ? wd[15:0] * 32'h0001_0001 : wd;
            exp_wr_to = wr_ack_on ? A : A + T;
            exp_to = !wr_ack_on;
            exp_rsp = wr_ack_on ? A + 1 : A + T + 1;
        end else begin
            exp_rd = A;
            exp_to = !(lat >= 1 && lat <= T);
            k = exp_to ? T + 1 : lat + 1;
            exp_rsp = A + k;
            exp_rdata = exp_to ? 32'h0 : model_load(w, a, word);
        end
        busy_to = exp_rsp;
        req_valid = 1'b1;
        req_is_store = st;
        req_width = w;
        req_addr = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (cyc <= exp_rsp && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL %s: no response within 100 cycles, want one at cyc %0d", name, exp_rsp);
        end
    endtask

    // Assert sync_reset for one edge mid-transfer and drop the cancelled expectations.
    task automatic mid_reset();
        sync_reset = 1'b1;
        exp_rsp = -1;
        busy_to = cyc;
        if (exp_wr_to > cyc) exp_wr_to = cyc;
        @(posedge clk);
        #1;
        sync_reset = 1'b0;
        chk("after_reset_ready", 32'(req_ready), 32'd1);
        chk("after_reset_rd_en", 32'(mem_read_en), 32'd0);
        chk("after_reset_wr_en", 32'(mem_write_en), 32'd0);
        chk("after_reset_rsp", 32'(rsp_valid), 32'd0);
    endtask

    // Memory controller read side: ack rd_lat cycles after the strobe is seen.
    initial begin
        mem_read_ack = 1'b0;
        mem_read_data = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_read_en === 1'b1 && rd_lat >= 0) begin
                repeat (rd_lat) @(posedge clk);
                #1;
                mem_read_ack = 1'b1;
                mem_read_data = rd_word;
                @(posedge clk);
                #1;
                mem_read_ack = 1'b0;
                mem_read_data = 32'h0;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model's expectations.
    always @(negedge clk) begin
        if (checking) begin
            logic e_v, in_wr;
            e_v = (cyc == exp_rsp);
            in_wr = (cyc >= exp_wr_from) && (cyc <= exp_wr_to);
            chk("rsp_valid", 32'(rsp_valid), 32'(e_v));
            chk("rsp_rdata", rsp_rdata, e_v ? exp_rdata : 32'h0);
            chk("rsp_misaligned", 32'(rsp_misaligned), e_v ? 32'(exp_mis) : 32'd0);
            chk("rsp_timeout", 32'(rsp_timeout), e_v ? 32'(exp_to) : 32'd0);
            chk("mem_read_en", 32'(mem_read_en), 32'(cyc == exp_rd));
            chk("mem_write_en", 32'(mem_write_en), in_wr ? 32'(exp_wen) : 32'd0);
            if (in_wr) chk("mem_write_data", mem_write_data, exp_wdata);
            if (in_wr || cyc == exp_rd) chk("mem_addr", 32'(mem_addr), 32'(exp_waddr));
            chk("req_ready", 32'(req_ready), 32'(!(cyc >= busy_from && cyc <= busy_to)));
            if (rsp_valid === 1'b1) begin
                got_rdata = rsp_rdata;
                got_mis = rsp_misaligned;
                got_to = rsp_timeout;
                got_cyc = cyc;
            end
        end
    end

    initial begin
        sync_reset = 1'b1;
        req_valid = 1'b0;
        req_is_store = 1'b0;
        req_width = 3'b000;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        sync_reset = 1'b0;
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_strobes", {27'd0, mem_write_en, mem_read_en}, 32'd0);
        checking = 1'b1;

        issue(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2);
        chk("lw_addr", 32'(mem_addr), 32'h0000_0040);
        chk("lw_strobe", 32'(mem_read_en), 32'd1);
        wait_done("lw");
        chk("lw_data", got_rdata, 32'hDEADBEEF);
        chk("lw_latency", 32'(got_cyc - acc), 32'd3);

        issue(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 2);
        wait_done("lb");
        chk("lb_data", got_rdata, 32'hFFFFFF80);
        issue(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 2);
        wait_done("lbu");
        chk("lbu_data", got_rdata, 32'h00000080);
        issue(1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 2);
        wait_done("lh");
        chk("lh_data", got_rdata, 32'hFFFF80FF);
        issue(1'b0, 3'b101, 32'h100, 32'h0, 32'h80FF1234, 3);
        wait_done("lhu");
        chk("lhu_data", got_rdata, 32'h00001234);

        wr_ack_on = 1'b1;
        issue(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, -1);
        chk("sh_en", 32'(mem_write_en), 32'h0000_000C);
        chk("sh_data", mem_write_data, 32'hABCDABCD);
        wait_done("sh");
        chk("sh_latency", 32'(got_cyc - acc), 32'd1);
        issue(1'b1, 3'b000, 32'h101, 32'h0000005A, 32'h0, -1);
        chk("sb_en", 32'(mem_write_en), 32'h0000_0002);
        chk("sb_data", mem_write_data, 32'h5A5A5A5A);
        wait_done("sb");

        issue(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 2);
        wait_done("lw_mis");
        chk("lw_mis_flag", 32'(got_mis), 32'd1);
        chk("lw_mis_latency", 32'(got_cyc - acc), 32'd0);
        issue(1'b1, 3'b101, 32'h100, 32'h0, 32'h0, -1);
        wait_done("s_hu");
        chk("s_hu_flag", 32'(got_mis), 32'd1);

        issue(1'b0, 3'b010, 32'h108, 32'h0, 32'h13579BDF, T);
        wait_done("ack_at_limit");
        chk("limit_timeout", 32'(got_to), 32'd0);
        chk("limit_data", got_rdata, 32'h13579BDF);
        chk("limit_latency", 32'(got_cyc - acc), 32'(T + 1));

        issue(1'b0, 3'b010, 32'h10C, 32'h0, 32'h55AA55AA, T + 5);
        wait_done("timeout");
        chk("timeout_flag", 32'(got_to), 32'd1);
        chk("timeout_data", got_rdata, 32'h0);
        chk("timeout_latency", 32'(got_cyc + 1 - acc), 32'(T + 2));
        repeat (8) @(posedge clk);
        #1;
        chk("late_ack_ready", 32'(req_ready), 32'd1);

        issue(1'b0, 3'b010, 32'h110, 32'h0, 32'h0, -1);
        @(posedge clk);
        #1;
        mid_reset();
        issue(1'b1, 3'b010, 32'h104, 32'h11223344, 32'h0, -1);
        chk("sw_en", 32'(mem_write_en), 32'h0000_000F);
        wait_done("sw_after_reset");

        wr_ack_on = 1'b0;
        issue(1'b1, 3'b010, 32'h108, 32'h99887766, 32'h0, -1);
        @(posedge clk);
        #1;
        mid_reset();
        wr_ack_on = 1'b1;
        issue(1'b0, 3'b010, 32'h100, 32'h0, 32'hCAFEF00D, 2);
        wait_done("lw_after_reset");
        chk("lw_after_reset_data", got_rdata, 32'hCAFEF00D);

        repeat (3) @(posedge clk);
        #1;
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
